// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Parametrised pipeline stage register with valid/ready handshaking. A
//   2-entry skid buffer (main + skid) gives full throughput under
//   back-pressure. in_ready_o is a decode of registered state only, so there
//   is no combinational path from out_ready_i back to in_ready_o. A
//   synchronous flush inserts bubbles. A saturating counter records stall
//   cycles for performance debug.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset (beats flush)
//   flush_i      in   1       synchronous flush, discards held entries
//   in_valid_i   in   1       upstream entry valid
//   in_ready_o   out  1       stage can accept this cycle
//   in_ctrl_i    in   CTRL_W  upstream control field
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       downstream entry valid
//   out_ready_i  in   1       downstream accepts this cycle
//   out_ctrl_o   out  CTRL_W  control field, forced to 0 when not valid
//   out_data_o   out  DATA_W  payload, don't-care when not valid
//   occupancy_o  out  2       entries held (0..2)
//   stall_cnt_o  out  CNT_W   saturating count of valid & !ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_acc;
    logic                w_pop;
    logic                w_stall;

    assign w_in_ready  = (r_state != S_TWO);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = in_valid_i & w_in_ready;
    assign w_pop       = w_out_valid & out_ready_i;
    assign w_stall     = w_out_valid & ~out_ready_i;

    // Payload registers load only on an accept, so X on the inputs while
    // in_valid_i is low never reaches the held state.
    always_ff @(posedge clk_i) begin
        // NOTE: every register here uses non-blocking assignment so all state
        // updates see the pre-edge values regardless of statement order.
        if (rst_i) begin
            // NOTE: data registers are reset too, because out_data_o must read
            // 0 after reset; these are a handful of flops, not a memory array.
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                // Both entries and any same-cycle accept are dropped; data
                // registers keep stale contents, hidden by out_valid_o = 0.
                r_state <= S_EMPTY;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_acc) begin
                            r_state     <= S_ONE;
                            r_main_ctrl <= in_ctrl_i;
                            r_main_data <= in_data_i;
                        end
                    end
                    S_ONE: begin
                        if (w_acc && w_pop) begin
                            r_main_ctrl <= in_ctrl_i;
                            r_main_data <= in_data_i;
                        end else if (w_acc) begin
                            // Main is blocked; park the younger entry in skid.
                            r_state     <= S_TWO;
                            r_skid_ctrl <= in_ctrl_i;
                            r_skid_data <= in_data_i;
                        end else if (w_pop) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        // in_ready_o is low here, so only a pop can happen;
                        // the skid entry is older than anything upstream.
                        if (w_pop) begin
                            r_state     <= S_ONE;
                            r_main_ctrl <= r_skid_ctrl;
                            r_main_data <= r_skid_data;
                        end
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end

            // Flush does not clear the debug counter.
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    // Bubbles must never carry a register write downstream.
    assign out_ctrl_o  = w_out_valid ? r_main_ctrl : '0;
    assign out_data_o  = r_main_data;
    assign occupancy_o = r_state;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int CTRL_W = 2;
    localparam int DATA_W = 69;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_ready_i;

    logic              in_ready_o;
    logic              out_valid_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Second instance with a 4-bit counter, driven by the same stimulus.
    logic              s_in_ready_o;
    logic              s_out_valid_o;
    logic [CTRL_W-1:0] s_out_ctrl_o;
    logic [DATA_W-1:0] s_out_data_o;
    logic [1:0]        s_occupancy_o;
    logic [3:0]        s_stall_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut_s (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (s_in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (s_out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (s_out_ctrl_o),
        .out_data_o  (s_out_data_o),
        .occupancy_o (s_occupancy_o),
        .stall_cnt_o (s_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later,
    // and new inputs driven there are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input int d);
        in_valid_i = v;
        in_ctrl_i  = c;
        in_data_i  = DATA_W'(d);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b1, 2'b11, 32'h5A5A);
        tick();
        tick();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
        total++; if (out_ctrl_o !== 2'b00) begin bad++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl_o); end
        total++; if (out_data_o !== '0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy_o); end
        total++; if (stall_cnt_o !== '0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt_o); end
        rst_i = 1'b0;
        drive(1'b0, 2'b00, 0);
        tick();
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'b11, i);
            tick();
            total++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(i) || out_ctrl_o !== 2'b11)
                begin bad++; $display("FAIL stream_out[%0d] got v=%0b c=%0h d=%0h exp v=1 c=3 d=%0h", i, out_valid_o, out_ctrl_o, out_data_o, i); end
            total++; if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1)
                begin bad++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occupancy_o, in_ready_o); end
        end
        drive(1'b0, 2'b00, 0);
        tick();
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 2'b00 || occupancy_o !== 2'd0)
            begin bad++; $display("FAIL stream_drain got v=%0b c=%0h occ=%0d exp v=0 c=0 occ=0", out_valid_o, out_ctrl_o, occupancy_o); end
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_back_pressure();
        out_ready_i = 1'b0;
        drive(1'b1, 2'b01, 32'hA);
        tick();
        total++; if (occupancy_o !== 2'd1 || out_data_o !== DATA_W'(32'hA) || in_ready_o !== 1'b1 || stall_cnt_o !== 16'd0)
            begin bad++; $display("FAIL bp_a got occ=%0d d=%0h rdy=%0b st=%0d exp occ=1 d=a rdy=1 st=0", occupancy_o, out_data_o, in_ready_o, stall_cnt_o); end
        drive(1'b1, 2'b10, 32'hB);
        tick();
        total++; if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== DATA_W'(32'hA) || out_ctrl_o !== 2'b01 || stall_cnt_o !== 16'd1)
            begin bad++; $display("FAIL bp_b got occ=%0d rdy=%0b d=%0h c=%0h st=%0d exp occ=2 rdy=0 d=a c=1 st=1", occupancy_o, in_ready_o, out_data_o, out_ctrl_o, stall_cnt_o); end
        drive(1'b1, 2'b11, 32'hC);
        tick();
        total++; if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== DATA_W'(32'hA) || stall_cnt_o !== 16'd2)
            begin bad++; $display("FAIL bp_c_held got occ=%0d rdy=%0b d=%0h st=%0d exp occ=2 rdy=0 d=a st=2", occupancy_o, in_ready_o, out_data_o, stall_cnt_o); end
        tick();
        total++; if (stall_cnt_o !== 16'd3) begin bad++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt_o); end
        out_ready_i = 1'b1;
        tick();
        total++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(32'hB) || out_ctrl_o !== 2'b10 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1)
            begin bad++; $display("FAIL bp_out_b got v=%0b d=%0h c=%0h occ=%0d rdy=%0b exp v=1 d=b c=2 occ=1 rdy=1", out_valid_o, out_data_o, out_ctrl_o, occupancy_o, in_ready_o); end
        tick();
        total++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(32'hC) || out_ctrl_o !== 2'b11)
            begin bad++; $display("FAIL bp_out_c got v=%0b d=%0h c=%0h exp v=1 d=c c=3", out_valid_o, out_data_o, out_ctrl_o); end
        drive(1'b0, 2'b00, 0);
        tick();
        total++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || stall_cnt_o !== 16'd3)
            begin bad++; $display("FAIL bp_drain got v=%0b occ=%0d st=%0d exp v=0 occ=0 st=3", out_valid_o, occupancy_o, stall_cnt_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        drive(1'b1, 2'b01, 32'hD);
        tick();
        drive(1'b1, 2'b10, 32'hE);
        tick();
        total++; if (occupancy_o !== 2'd2 || stall_cnt_o !== 16'd4)
            begin bad++; $display("FAIL flush_pre got occ=%0d st=%0d exp occ=2 st=4", occupancy_o, stall_cnt_o); end
        flush_i = 1'b1;
        drive(1'b1, 2'b11, 32'hF);
        tick();
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 2'b00 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1)
            begin bad++; $display("FAIL flush_empty got v=%0b c=%0h occ=%0d rdy=%0b exp v=0 c=0 occ=0 rdy=1", out_valid_o, out_ctrl_o, occupancy_o, in_ready_o); end
        total++; if (stall_cnt_o !== 16'd5) begin bad++; $display("FAIL flush_stall got=%0d exp=5", stall_cnt_o); end
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 2'b00, 0);
        tick();
        total++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || stall_cnt_o !== 16'd5)
            begin bad++; $display("FAIL flush_dropped got v=%0b occ=%0d st=%0d exp v=0 occ=0 st=5", out_valid_o, occupancy_o, stall_cnt_o); end
    endtask

    task automatic test_saturation();
        rst_i = 1'b1;
        drive(1'b0, 2'b00, 0);
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b1, 2'b01, 32'h77);
        tick();
        drive(1'b0, 2'b00, 0);
        total++; if (s_out_valid_o !== 1'b1 || s_stall_cnt_o !== 4'd0)
            begin bad++; $display("FAIL sat_start got v=%0b st=%0d exp v=1 st=0", s_out_valid_o, s_stall_cnt_o); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++; if (s_stall_cnt_o !== 4'((k > 15) ? 15 : k))
                begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, s_stall_cnt_o, (k > 15) ? 15 : k); end
        end
        total++; if (stall_cnt_o !== 16'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt_o); end
    endtask

    task automatic test_reset_vs_flush();
        out_ready_i = 1'b0;
        drive(1'b1, 2'b10, 32'h99);
        tick();
        total++; if (occupancy_o !== 2'd2 || out_data_o !== DATA_W'(32'h77))
            begin bad++; $display("FAIL rvf_pre got occ=%0d d=%0h exp occ=2 d=77", occupancy_o, out_data_o); end
        rst_i = 1'b1;
        flush_i = 1'b1;
        drive(1'b1, 2'b11, 32'h55);
        tick();
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 2'b00 || out_data_o !== '0 || in_ready_o !== 1'b1 || occupancy_o !== 2'd0 || stall_cnt_o !== '0)
            begin bad++; $display("FAIL rvf_reset got v=%0b c=%0h d=%0h rdy=%0b occ=%0d st=%0d exp v=0 c=0 d=0 rdy=1 occ=0 st=0", out_valid_o, out_ctrl_o, out_data_o, in_ready_o, occupancy_o, stall_cnt_o); end
        rst_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 2'b00, 0);
        tick();
        total++; if (out_valid_o !== 1'b0 || out_data_o !== '0)
            begin bad++; $display("FAIL rvf_no_replay got v=%0b d=%0h exp v=0 d=0", out_valid_o, out_data_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 2'b00, 0);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_reset_vs_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
